// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one row at a time,
// debounces press and release, and shifts accepted key codes into a 4-digit buffer.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       clr,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] dig4
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       col_meta_reg, col_sync_reg;
  logic [DIV_W-1:0] div_reg;
  logic [1:0]       r_reg, r_next;
  logic [3:0]       row_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       cand_reg, cand_next;
  logic [3:0]       key_reg;
  logic             key_valid_reg;
  logic             key_held_reg, held_next;
  logic [15:0]      dig_reg;

  logic       tick;
  logic       press;
  logic [1:0] c_low;
  logic [3:0] code;
  logic       accept;

  assign tick  = (div_reg == DIV_LAST);
  assign press = (col_sync_reg != 4'b1111);
  assign code  = {r_reg, c_low};

  // Lowest-index active column wins when several are low.
  always_comb begin
    c_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_sync_reg[i]) c_low = 2'(i);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cand_next  = cand_reg;
    r_next     = r_reg;
    accept     = 1'b0;
    if (tick) begin
      case (state_reg)
        IDLE: begin
          if (press) begin
            cand_next = code;
            cnt_next  = CNT_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              accept     = 1'b1;
              state_next = PRESSED;
            end else begin
              state_next = DEBOUNCE;
            end
          end else begin
            r_next = r_reg + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (press && (code == cand_reg)) begin
            cnt_next = cnt_reg + CNT_ONE;
            if (cnt_next == CNT_DONE) begin
              accept     = 1'b1;
              state_next = PRESSED;
            end
          end else begin
            state_next = IDLE;
            r_next     = r_reg + 2'd1;
          end
        end
        PRESSED: begin
          if (!press) begin
            cnt_next = CNT_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              state_next = IDLE;
              r_next     = r_reg + 2'd1;
            end else begin
              state_next = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (!press) begin
            cnt_next = cnt_reg + CNT_ONE;
            if (cnt_next == CNT_DONE) begin
              state_next = IDLE;
              r_next     = r_reg + 2'd1;
            end
          end else begin
            // Any contact during release counts as the same key still held.
            state_next = PRESSED;
            cnt_next   = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign held_next = (state_next == PRESSED) || (state_next == RELEASE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      col_meta_reg  <= 4'b1111;
      col_sync_reg  <= 4'b1111;
      div_reg       <= '0;
      r_reg         <= 2'd0;
      row_reg       <= 4'b1110;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cand_reg      <= 4'd0;
      key_reg       <= 4'd0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
      dig_reg       <= 16'd0;
    end else begin
      col_meta_reg  <= col;
      col_sync_reg  <= col_meta_reg;
      div_reg       <= tick ? '0 : div_reg + DIV_W'(1);
      r_reg         <= r_next;
      row_reg       <= ~(4'b0001 << r_next);
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cand_reg      <= cand_next;
      key_valid_reg <= accept;
      key_held_reg  <= held_next;
      if (accept) begin
        key_reg <= cand_next;
        dig_reg <= {dig_reg[11:0], cand_next};
      end
    end
  end

  assign row       = row_reg;
  assign key       = key_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;
  assign dig1      = dig_reg[3:0];
  assign dig2      = dig_reg[7:4];
  assign dig3      = dig_reg[11:8];
  assign dig4      = dig_reg[15:12];

endmodule
